// File: rtl/calc_pkg.sv
// Shared constants and helpers for the calculator datapath blocks.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 16;
    localparam int unsigned CALC_DEPTH = 4;

    // True when an address selects an implemented entry.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: address range check, write-first bypass and output flops.
module regfile_rdport
    import calc_pkg::*;
#(
    parameter int unsigned     WIDTH     = CALC_WIDTH,
    parameter int unsigned     DEPTH     = CALC_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned     AW        = 2
) (
    input  logic             ck,
    input  logic             res,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0] valid,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    logic rd_ok_c;
    logic bypass_c;

    assign rd_ok_c  = addr_ok(32'(rsel), DEPTH);
    assign bypass_c = we && (wsel == rsel);

    // Clear wins over bypass so a dropped write is never forwarded.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            q <= '0;
            v <= 1'b0;
        end else if (clr) begin
            q <= RESET_VAL;
            v <= 1'b0;
        end else if (!rd_ok_c) begin
            q <= '0;
            v <= 1'b0;
        end else if (bypass_c) begin
            q <= d;
            v <= 1'b1;
        end else begin
            q <= mem[rsel];
            v <= valid[rsel];
        end
    end

endmodule

// File: rtl/regfile_n.sv
// Flop-based register file with one write port and two registered read ports.
module regfile_n
    import calc_pkg::*;
#(
    parameter int unsigned      WIDTH     = CALC_WIDTH,
    parameter int unsigned      DEPTH     = CALC_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     AW        = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
    input  logic             ck,
    input  logic             res,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel_a,
    input  logic [AW-1:0]    rsel_b,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic             va,
    output logic             vb,
    output logic [DEPTH-1:0] valid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_hit_c;

    // Out-of-range writes are squashed here so both ports see a clean strobe.
    assign wr_hit_c = we && !clr && addr_ok(32'(wsel), DEPTH);

    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
            valid <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
            valid <= '0;
        end else if (wr_hit_c) begin
            mem[wsel]   <= d;
            valid[wsel] <= 1'b1;
        end
    end

    regfile_rdport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL), .AW(AW)
    ) u_rd_a (
        .ck(ck), .res(res), .clr(clr), .we(wr_hit_c), .wsel(wsel), .d(d),
        .rsel(rsel_a), .mem(mem), .valid(valid), .q(qa), .v(va)
    );

    regfile_rdport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL), .AW(AW)
    ) u_rd_b (
        .ck(ck), .res(res), .clr(clr), .we(wr_hit_c), .wsel(wsel), .d(d),
        .rsel(rsel_b), .mem(mem), .valid(valid), .q(qb), .v(vb)
    );

endmodule

// File: doc/regfile_n.md
REGFILE_N -- requirements
Module: regfile_n

Interface
REQ-001 Parameter WIDTH, default 16, is the data width of each register in bits.
REQ-002 Parameter DEPTH, default 4, is the number of registers; legal range 2..256.
REQ-003 Parameter RESET_VAL, default 0, is the WIDTH-bit value loaded into every register on reset or clear.
REQ-004 Derived constant AW SHALL be clog2(DEPTH) and SHALL be at least 1.
REQ-005 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 ck  input  1  clock; all state changes on the rising edge.
REQ-007 res  input  1  asynchronous active-high reset.
REQ-008 clr  input  1  synchronous clear of all registers and valid bits.
REQ-009 we  input  1  write enable.
REQ-010 wsel  input  AW  write address.
REQ-011 d  input  WIDTH  write data.
REQ-012 rsel_a  input  AW  read address, port A.
REQ-013 rsel_b  input  AW  read address, port B.
REQ-014 qa  output  WIDTH  registered read data, port A.
REQ-015 qb  output  WIDTH  registered read data, port B.
REQ-016 va  output  1  valid flag of the entry read on port A, aligned with qa.
REQ-017 vb  output  1  valid flag of the entry read on port B, aligned with qb.
REQ-018 valid  output  DEPTH  per-entry written-since-clear bitmask.

Function
REQ-019 A write SHALL occur on a rising ck edge when we=1, clr=0 and wsel<DEPTH: reg[wsel]<=d and valid[wsel]<=1.
REQ-020 A write with wsel>=DEPTH SHALL be ignored with no state change.
REQ-021 Reads SHALL have 1-cycle latency: qa and va SHALL reflect rsel_a as sampled at the previous rising edge, and qb and vb SHALL do the same for rsel_b.
REQ-022 When a same-edge write targets the read address, the read SHALL be write-first (bypass): q<=d and v<=1.
REQ-023 A read with rsel>=DEPTH SHALL return q=0 and v=0.
REQ-024 Both ports SHALL operate independently and may read the same address in the same cycle with identical results.
REQ-025 When clr=1, all registers SHALL load RESET_VAL and valid SHALL clear to 0 on the next edge.
REQ-026 A write in a clr cycle SHALL be dropped, because clr has priority over we.
REQ-027 Reads sampled in a clr cycle SHALL return q=RESET_VAL and v=0 (clear-first).
REQ-028 The output registers SHALL update every cycle; there is no read enable.

Reset
REQ-029 On res=1, asynchronously, all registers SHALL be set to RESET_VAL, and valid, qa, qb, va and vb SHALL be set to 0.
REQ-030 Reset asserted mid-operation SHALL abort any write in that cycle.
REQ-031 The first write SHALL take effect at the first rising edge after res deasserts.
REQ-032 Reset SHALL override clr and we.

Structure
REQ-033 The default WIDTH and DEPTH constants SHALL live in the shared package calc_pkg, so that calculator datapath blocks agree on them.
REQ-034 The one read port (address mux, range check, bypass, output register) SHALL be a sub-module, regfile_rdport, instantiated twice.
REQ-035 Storage SHALL be a DEPTH x WIDTH flop array with no vendor RAM macros.

Verification
REQ-036 Reset: hold res=1 for 2 cycles -> qa=qb=0, va=vb=0, valid=0; after release, read all addresses -> q=RESET_VAL, v=0.
REQ-037 Basic write/read: write 16'h4c55 to addr 0 and 16'h1234 to addr 3; next cycle rsel_a=0 and rsel_b=3 -> one cycle later qa=4c55, qb=1234, va=vb=1, valid=4'b1001.
REQ-038 Bypass: we=1, wsel=2, d=16'hBEEF and rsel_a=rsel_b=2 on the same edge -> next cycle qa=qb=BEEF, va=vb=1.
REQ-039 Clear priority: clr=1 with we=1, wsel=1, d=16'hAAAA -> valid=0 and reg1=RESET_VAL; a subsequent read of addr 1 gives q=0, v=0.
REQ-040 Range check with DEPTH=5 (AW=3): write to wsel=6 -> valid unchanged; rsel_a=7 -> qa=0, va=0.
REQ-041 Async reset mid-write: assert res between edges while we=1 -> outputs go to 0 immediately and the pending write is lost.
